// File: rtl/ex_pipe_stage.sv
// Execute stage: ALU with MEM/WB operand forwarding, iterative shift-add multiplier,
// and a registered EX/MEM output held under valid/ready backpressure.
module ex_pipe_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [DATA_W-1:0] imm,
   input  logic [DATA_W-1:0] pc_plus4,
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [REG_AW-1:0] rt_addr,
   input  logic [REG_AW-1:0] rd_addr,
   input  logic [1:0]        alu_op,
   input  logic              alu_src,
   input  logic              reg_dst,
   input  logic              reg_write,
   input  logic              fwd_mem_we,
   input  logic              fwd_wb_we,
   input  logic [REG_AW-1:0] fwd_mem_addr,
   input  logic [REG_AW-1:0] fwd_wb_addr,
   input  logic [DATA_W-1:0] fwd_mem_data,
   input  logic [DATA_W-1:0] fwd_wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_zero,
   output logic [DATA_W-1:0] out_branch_target,
   output logic [REG_AW-1:0] out_write_reg,
   output logic              out_reg_write,
   output logic [DATA_W-1:0] out_rt_data
);

   localparam int              CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_MUL = 6'b011000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic              accept_s, is_mul_s, mul_done_s, in_ready_s, alu_we_s;
   logic [DATA_W-1:0] op_a_s, op_b_s, fwd_rt_s, alu_res_s, target_s, prod_s;
   logic [REG_AW-1:0] wreg_s;

   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
   logic [DATA_W-1:0] pend_target_q, pend_rt_q;
   logic [REG_AW-1:0] pend_wreg_q;
   logic              pend_rwe_q;

   logic              out_valid_q, out_zero_q, out_rwe_q;
   logic [DATA_W-1:0] out_result_q, out_target_q, out_rt_q;
   logic [REG_AW-1:0] out_wreg_q;

   // Register 0 never forwards; MEM wins over WB when both match.
   function automatic logic [DATA_W-1:0] fwd_pick(
      input logic [REG_AW-1:0] src,
      input logic [DATA_W-1:0] rf_val,
      input logic              mem_we,
      input logic [REG_AW-1:0] mem_addr,
      input logic [DATA_W-1:0] mem_val,
      input logic              wb_we,
      input logic [REG_AW-1:0] wb_addr,
      input logic [DATA_W-1:0] wb_val
   );
      logic [DATA_W-1:0] v;
      if (src == '0)                        v = rf_val;
      else if (mem_we && (mem_addr == src)) v = mem_val;
      else if (wb_we && (wb_addr == src))   v = wb_val;
      else                                  v = rf_val;
      return v;
   endfunction

   assign op_a_s     = fwd_pick(rs_addr, rs_data, fwd_mem_we, fwd_mem_addr, fwd_mem_data,
                                fwd_wb_we, fwd_wb_addr, fwd_wb_data);
   assign fwd_rt_s   = fwd_pick(rt_addr, rt_data, fwd_mem_we, fwd_mem_addr, fwd_mem_data,
                                fwd_wb_we, fwd_wb_addr, fwd_wb_data);
   assign op_b_s     = alu_src ? imm : fwd_rt_s;
   assign is_mul_s   = (alu_op == 2'b10) && (imm[5:0] == F_MUL);
   assign accept_s   = in_valid && in_ready_s;
   assign mul_done_s = (state_q == S_MUL) && (cnt_q == CNT_LAST);
   assign target_s   = pc_plus4 + {imm[DATA_W-3:0], 2'b00};
   assign wreg_s     = reg_dst ? rd_addr : rt_addr;
   assign prod_s     = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Single-cycle ALU; an unknown funct yields zero and suppresses the write.
   always_comb begin
      alu_res_s = '0;
      alu_we_s  = reg_write;
      case (alu_op)
         2'b00: alu_res_s = op_a_s + op_b_s;
         2'b01: alu_res_s = op_a_s - op_b_s;
         2'b11: alu_res_s = op_a_s | op_b_s;
         2'b10: begin
            case (imm[5:0])
               F_ADD:   alu_res_s = op_a_s + op_b_s;
               F_SUB:   alu_res_s = op_a_s - op_b_s;
               F_AND:   alu_res_s = op_a_s & op_b_s;
               F_OR:    alu_res_s = op_a_s | op_b_s;
               F_SLT:   alu_res_s = ($signed(op_a_s) < $signed(op_b_s)) ?
                                    {{(DATA_W-1){1'b0}}, 1'b1} : '0;
               F_MUL:   alu_res_s = '0;
               default: begin
                  alu_res_s = '0;
                  alu_we_s  = 1'b0;
               end
            endcase
         end
         default: alu_res_s = '0;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) state_d = is_mul_s ? S_MUL : S_HOLD;
            else          state_d = S_IDLE;
         end
         S_MUL: begin
            if (cnt_q == CNT_LAST) state_d = S_HOLD;
            else                   state_d = S_MUL;
         end
         S_HOLD: begin
            if (out_ready && in_valid) state_d = is_mul_s ? S_MUL : S_HOLD;
            else if (out_ready)        state_d = S_IDLE;
            else                       state_d = S_HOLD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM output: upstream ready.
   always_comb begin
      in_ready_s = 1'b0;
      if (reset && (state_q != S_MUL)) in_ready_s = (state_q == S_IDLE) || out_ready;
      else                             in_ready_s = 1'b0;
   end

   // Shift-add multiplier; operands and sideband are latched at acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q         <= '0;
         mcand_q       <= '0;
         mplier_q      <= '0;
         acc_q         <= '0;
         pend_target_q <= '0;
         pend_rt_q     <= '0;
         pend_wreg_q   <= '0;
         pend_rwe_q    <= 1'b0;
      end else if (accept_s && is_mul_s) begin
         cnt_q         <= '0;
         mcand_q       <= op_a_s;
         mplier_q      <= op_b_s;
         acc_q         <= '0;
         pend_target_q <= target_s;
         pend_rt_q     <= fwd_rt_s;
         pend_wreg_q   <= wreg_s;
         pend_rwe_q    <= reg_write;
      end else if (state_q == S_MUL) begin
         cnt_q    <= cnt_q + CNT_ONE;
         mcand_q  <= {mcand_q[DATA_W-2:0], 1'b0};
         mplier_q <= {1'b0, mplier_q[DATA_W-1:1]};
         acc_q    <= prod_s;
      end
   end

   // EX/MEM output register: loads on accept or multiply completion, clears valid on pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_zero_q   <= 1'b0;
         out_target_q <= '0;
         out_wreg_q   <= '0;
         out_rwe_q    <= 1'b0;
         out_rt_q     <= '0;
      end else if (accept_s && !is_mul_s) begin
         out_valid_q  <= 1'b1;
         out_result_q <= alu_res_s;
         out_zero_q   <= (alu_res_s == '0);
         out_target_q <= target_s;
         out_wreg_q   <= wreg_s;
         out_rwe_q    <= alu_we_s;
         out_rt_q     <= fwd_rt_s;
      end else if (accept_s) begin
         out_valid_q <= 1'b0;
      end else if (mul_done_s) begin
         out_valid_q  <= 1'b1;
         out_result_q <= prod_s;
         out_zero_q   <= (prod_s == '0);
         out_target_q <= pend_target_q;
         out_wreg_q   <= pend_wreg_q;
         out_rwe_q    <= pend_rwe_q;
         out_rt_q     <= pend_rt_q;
      end else if ((state_q == S_HOLD) && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign in_ready          = in_ready_s;
   assign out_valid         = out_valid_q;
   assign out_result        = out_result_q;
   assign out_zero          = out_zero_q;
   assign out_branch_target = out_target_q;
   assign out_write_reg     = out_wreg_q;
   assign out_reg_write     = out_rwe_q;
   assign out_rt_data       = out_rt_q;

endmodule
